// File: rtl/game_pkg.sv
// Shared types for the memory-game auto player: FSM states and
// the LED one-hot to button-ID decoder.
package game_pkg;

    localparam int LED_ID_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        REPLAY_PRESS,
        REPLAY_GAP
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [LED_ID_W-1:0] id;
    } led_id_t;

    function automatic led_id_t onehot_to_id(input logic [3:0] v);
        led_id_t r;
        r.valid = 1'b1;
        r.id    = '0;
        case (v)
            4'b0001: r.id = 2'd0;
            4'b0010: r.id = 2'd1;
            4'b0100: r.id = 2'd2;
            4'b1000: r.id = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/game_auto_player_if.sv
// Game-side bundle of the auto player: LEDs in, switches out, status.
// AUTO_PLAYER_MISTAKE_EN adds the i_Inject_Err request line.
interface game_auto_player_if #(
    parameter int CNT_W = 4
);
    logic             i_Enable;
    logic             i_LED_1;
    logic             i_LED_2;
    logic             i_LED_3;
    logic             i_LED_4;
    logic             o_Switch_1;
    logic             o_Switch_2;
    logic             o_Switch_3;
    logic             o_Switch_4;
    logic             o_Busy;
    logic [CNT_W-1:0] o_Count;
    logic             o_Overflow;
`ifdef AUTO_PLAYER_MISTAKE_EN
    logic             i_Inject_Err;

    modport master (
        output i_Enable, i_LED_1, i_LED_2, i_LED_3, i_LED_4,
        output i_Inject_Err,
        input  o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4,
        input  o_Busy, o_Count, o_Overflow
    );

    modport slave (
        input  i_Enable, i_LED_1, i_LED_2, i_LED_3, i_LED_4,
        input  i_Inject_Err,
        output o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4,
        output o_Busy, o_Count, o_Overflow
    );
`else
    modport master (
        output i_Enable, i_LED_1, i_LED_2, i_LED_3, i_LED_4,
        input  o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4,
        input  o_Busy, o_Count, o_Overflow
    );

    modport slave (
        input  i_Enable, i_LED_1, i_LED_2, i_LED_3, i_LED_4,
        output o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4,
        output o_Busy, o_Count, o_Overflow
    );
`endif
endinterface

// File: rtl/game_interval_timer.sv
// Loadable down-counter shared by the idle, press and gap intervals;
// o_Expired is high once the count has reached zero.
module game_interval_timer #(
    parameter int W = 8
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Load,
    input  logic [W-1:0] i_Load_Val,
    output logic         o_Expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt <= '0;
        end else if (i_Load) begin
            cnt <= i_Load_Val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign o_Expired = (cnt == '0);

endmodule

// File: rtl/game_auto_player.sv
// Memory-game opponent: records one-hot LED flashes, then replays them
// as switch pulses. AUTO_PLAYER_MISTAKE_EN enables deliberate last-press errors.
module game_auto_player
    import game_pkg::*;
#(
    parameter int CLKS_PER_SEC = 25000000,
    parameter int MAX_PATTERN  = 11,
    parameter int PRESS_CLKS   = 4,
    parameter int GAP_CLKS     = CLKS_PER_SEC / 20,
    parameter int IDLE_CLKS    = CLKS_PER_SEC / 2
) (
    input logic               i_Clk,
    input logic               i_Rst_L,
    game_auto_player_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_PATTERN + 1);
    localparam int DEPTH = 2 ** CNT_W;
    localparam int T_PG  = (PRESS_CLKS > GAP_CLKS) ? PRESS_CLKS : GAP_CLKS;
    localparam int T_MAX = (IDLE_CLKS > T_PG) ? IDLE_CLKS : T_PG;
    localparam int T_W   = $clog2(T_MAX + 1);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    count, count_nx;
    logic [CNT_W-1:0]    idx, idx_nx;
    logic [LED_ID_W-1:0] mem [DEPTH];
    logic [LED_ID_W-1:0] play_id;
    logic [3:0]          led, led_q, rise, sw;
    led_id_t             hit;
    logic                edge_ok, full, store, last, overflow;
    logic                t_load, t_exp;
    logic [T_W-1:0]      t_val;

    assign led     = {bus.i_LED_4, bus.i_LED_3, bus.i_LED_2, bus.i_LED_1};
    assign rise    = led & ~led_q;
    assign hit     = onehot_to_id(led);
    assign edge_ok = bus.i_Enable && (state == CAPTURE) && (rise != '0) && hit.valid;
    assign full    = (count == CNT_W'(MAX_PATTERN));
    assign store   = edge_ok && !full;
    assign last    = (idx == count - CNT_W'(1));

`ifdef AUTO_PLAYER_MISTAKE_EN
    logic err_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            err_q <= 1'b0;
        end else if (state == CAPTURE && state_nx == REPLAY_PRESS) begin
            err_q <= bus.i_Inject_Err;
        end
    end

    assign play_id = mem[idx] + LED_ID_W'(err_q && last);
`else
    assign play_id = mem[idx];
`endif

    game_interval_timer #(.W(T_W)) u_timer (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Load     (t_load),
        .i_Load_Val (t_val),
        .o_Expired  (t_exp)
    );

    always_comb begin
        state_nx = state;
        count_nx = count;
        idx_nx   = idx;
        t_load   = 1'b0;
        t_val    = T_W'(IDLE_CLKS);
        if (!bus.i_Enable) begin
            state_nx = IDLE;
            count_nx = '0;
            idx_nx   = '0;
        end else begin
            unique case (state)
                IDLE: state_nx = CAPTURE;
                CAPTURE: begin
                    if (store) count_nx = count + CNT_W'(1);
                    // quiet time only counts once something has been captured
                    if (led != '0 || count == '0) begin
                        t_load = 1'b1;
                    end else if (t_exp) begin
                        state_nx = REPLAY_PRESS;
                        idx_nx   = '0;
                        t_load   = 1'b1;
                        t_val    = T_W'(PRESS_CLKS - 1);
                    end
                end
                REPLAY_PRESS: begin
                    if (t_exp) begin
                        state_nx = REPLAY_GAP;
                        t_load   = 1'b1;
                        t_val    = T_W'(GAP_CLKS - 1);
                    end
                end
                REPLAY_GAP: begin
                    if (t_exp && !last) begin
                        state_nx = REPLAY_PRESS;
                        idx_nx   = idx + CNT_W'(1);
                        t_load   = 1'b1;
                        t_val    = T_W'(PRESS_CLKS - 1);
                    end else if (t_exp) begin
                        state_nx = CAPTURE;
                        count_nx = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            count    <= '0;
            idx      <= '0;
            led_q    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            idx   <= idx_nx;
            led_q <= led;
            if (edge_ok && full) overflow <= 1'b1;
            if (store) mem[count] <= hit.id;
        end
    end

    always_comb begin
        sw = '0;
        if (state == REPLAY_PRESS) sw[play_id] = 1'b1;
    end

    assign bus.o_Switch_1 = sw[0];
    assign bus.o_Switch_2 = sw[1];
    assign bus.o_Switch_3 = sw[2];
    assign bus.o_Switch_4 = sw[3];
    assign bus.o_Busy     = (state == REPLAY_PRESS) || (state == REPLAY_GAP);
    assign bus.o_Count    = count;
    assign bus.o_Overflow = overflow;

endmodule

// File: tb/tb_game_auto_player.sv
// Directed bench for game_auto_player with short intervals
// (press 2, gap 3, idle 10, depth 11).
module tb_game_auto_player;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    game_auto_player_if #(.CNT_W(4)) bus ();

    game_auto_player #(
        .MAX_PATTERN (11),
        .PRESS_CLKS  (2),
        .GAP_CLKS    (3),
        .IDLE_CLKS   (10)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] sw;
    assign sw = {bus.o_Switch_4, bus.o_Switch_3, bus.o_Switch_2, bus.o_Switch_1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_led(input logic [3:0] v);
        bus.i_LED_1 = v[0];
        bus.i_LED_2 = v[1];
        bus.i_LED_3 = v[2];
        bus.i_LED_4 = v[3];
    endtask

    // Advance n clocks; with echo set, LEDs mirror the switches like the game
    task automatic step(input int n, input bit echo = 1'b0);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (echo) set_led(sw);
        end
    endtask

    task automatic pulse(input logic [3:0] v, input int on, input int off);
        set_led(v);
        step(on);
        set_led(4'b0000);
        step(off);
    endtask

    initial begin
        logic [3:0] prev_sw;
        int presses;
        int multi;
        bus.i_Enable = 1'b0;
        set_led(4'b0000);
`ifdef AUTO_PLAYER_MISTAKE_EN
        bus.i_Inject_Err = 1'b0;
`endif
        step(2);
        check("reset_sw", sw, 4'b0000);
        check("reset_busy", bus.o_Busy, 0);
        check("reset_count", bus.o_Count, 0);
        check("reset_ovf", bus.o_Overflow, 0);
        rst_n = 1'b1;
        bus.i_Enable = 1'b1;
        step(1);

        // Start combo: two LEDs together are never captured
        pulse(4'b0011, 5, 5);
        check("combo_count", bus.o_Count, 0);
        step(15);
        check("combo_busy", bus.o_Busy, 0);

        // Basic round: LED_3 then LED_1
        set_led(4'b0100);
        step(1);
        check("basic_first_store", bus.o_Count, 1);
        step(4);
        set_led(4'b0000);
        step(5);
        pulse(4'b0001, 5, 0);
        check("basic_count", bus.o_Count, 2);
        step(10);
        check("basic_quiet_sw", sw, 4'b0000);
        check("basic_quiet_busy", bus.o_Busy, 0);
        step(1);
        check("basic_p1_start", sw, 4'b0100);
        check("basic_busy", bus.o_Busy, 1);
        step(1);
        check("basic_p1_hold", sw, 4'b0100);
        step(1);
        check("basic_gap1", sw, 4'b0000);
        step(2);
        check("basic_gap3", sw, 4'b0000);
        step(1);
        check("basic_p2_start", sw, 4'b0001);
        step(1);
        check("basic_p2_hold", sw, 4'b0001);
        step(1);
        check("basic_p2_end", sw, 4'b0000);
        step(2);
        check("basic_gap_count", bus.o_Count, 2);
        step(1);
        check("basic_done_count", bus.o_Count, 0);
        check("basic_done_busy", bus.o_Busy, 0);

        // Echo immunity: LED_2 then LED_4, LEDs copy switches during replay
        pulse(4'b0010, 5, 5);
        pulse(4'b1000, 5, 0);
        step(11, 1'b1);
        check("echo_p1", sw, 4'b0010);
        check("echo_p1_count", bus.o_Count, 2);
        step(5, 1'b1);
        check("echo_p2", sw, 4'b1000);
        check("echo_p2_count", bus.o_Count, 2);
        step(5, 1'b1);
        check("echo_done_count", bus.o_Count, 0);
        set_led(4'b0000);
        step(2);
        check("echo_no_capture", bus.o_Count, 0);

        // Overflow: 12 pulses into an 11-deep buffer
        for (int i = 0; i < 11; i++) begin
            logic [3:0] v;
            v = 4'b0001 << (i % 4);
            pulse(v, 2, 2);
        end
        check("ovf_count_full", bus.o_Count, 11);
        check("ovf_not_yet", bus.o_Overflow, 0);
        pulse(4'b1000, 2, 0);
        check("ovf_count_hold", bus.o_Count, 11);
        check("ovf_set", bus.o_Overflow, 1);
        step(10);
        presses = 0;
        multi = 0;
        prev_sw = 4'b0000;
        for (int c = 0; c < 60; c++) begin
            step(1);
            if ($countones(sw) > 1) multi++;
            if (sw != 4'b0000 && prev_sw == 4'b0000) begin
                logic [3:0] e;
                e = 4'b0001 << (presses % 4);
                check($sformatf("ovf_press%0d", presses), sw, e);
                presses++;
            end
            prev_sw = sw;
        end
        check("ovf_presses", presses, 11);
        check("ovf_onehot", multi, 0);
        check("ovf_done_count", bus.o_Count, 0);
        check("ovf_sticky", bus.o_Overflow, 1);

        // Mid-replay disable during the second press
        pulse(4'b0001, 5, 5);
        pulse(4'b0010, 5, 0);
        step(16);
        check("dis_p2", sw, 4'b0010);
        bus.i_Enable = 1'b0;
        step(1);
        check("dis_sw", sw, 4'b0000);
        check("dis_busy", bus.o_Busy, 0);
        check("dis_count", bus.o_Count, 0);
        check("dis_ovf_kept", bus.o_Overflow, 1);
        pulse(4'b0100, 5, 5);
        check("dis_idle_ignores", bus.o_Count, 0);

        // Asynchronous reset in the middle of a press
        bus.i_Enable = 1'b1;
        step(1);
        pulse(4'b1000, 5, 0);
        step(11);
        check("rst_press", sw, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_sw", sw, 4'b0000);
        check("rst_ovf", bus.o_Overflow, 0);
        check("rst_count", bus.o_Count, 0);
        check("rst_busy", bus.o_Busy, 0);
        step(2);
        rst_n = 1'b1;

`ifdef AUTO_PLAYER_MISTAKE_EN
        // Mistake injection: LED_4, LED_2 replays as Switch_4, Switch_3
        bus.i_Inject_Err = 1'b1;
        step(1);
        pulse(4'b1000, 5, 5);
        pulse(4'b0010, 5, 0);
        step(11);
        check("err_p1", sw, 4'b1000);
        step(5);
        check("err_p2", sw, 4'b0100);
        step(5);
        check("err_done", bus.o_Count, 0);
        bus.i_Inject_Err = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
